// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side signals of alu_arbiter, bundled per requester pair.
// slave  : the arbiter's view.
// master : the requesters' and ALU's view.
interface alu_arbiter_if #(
    parameter int WIDTH = 16
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [3:0]       req0_ctrl;
    logic [3:0]       req1_ctrl;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_y;
    logic             busy;

    modport slave (
        input  req_valid, req0_ctrl, req1_ctrl, req0_a, req0_b, req1_a, req1_b,
        input  rsp_ready, alu_y,
        output req_ready, rsp_valid, rsp_data, alu_ctrl, alu_a, alu_b, busy
    );

    modport master (
        output req_valid, req0_ctrl, req1_ctrl, req0_a, req0_b, req1_a, req1_b,
        output rsp_ready, alu_y,
        input  req_ready, rsp_valid, rsp_data, alu_ctrl, alu_a, alu_b, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one multi-cycle ALU between two requesters, one operation
// at a time. Optional macro ALU_ARB_ROUND_ROBIN_EN selects round-robin on
// contention; without it requester 0 has fixed priority.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no operation; req_ready offered to the winning requester
// S_EXEC | operands on alu_*, counting down the ALU latency
// S_RESP | result held on rsp_data until the owner accepts it
module alu_arbiter #(
    parameter int WIDTH       = 16,
    parameter int ALU_LATENCY = 1
) (
    input  logic           clk,
    input  logic           resetn,
    alu_arbiter_if.slave   bus
);
    if (ALU_LATENCY < 1 || ALU_LATENCY > 15) begin : g_bad_latency
        $error("alu_arbiter: ALU_LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic [3:0]       alu_ctrl_q, alu_ctrl_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             grant;
    logic [1:0]       req_ready_c;

    // Pick the requester that would win if the arbiter were idle.
    always_comb begin
        grant = 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        if (bus.req_valid == 2'b11) begin
            grant = ~last_grant_q;
        end else begin
            grant = bus.req_valid[1];
        end
`else
        grant = ~bus.req_valid[0];
`endif
    end

    // Offer ready only to the winner, only while idle and out of reset.
    always_comb begin
        req_ready_c = 2'b00;
        if (state_q == S_IDLE && resetn) begin
            req_ready_c = grant ? {bus.req_valid[1], 1'b0} : {1'b0, bus.req_valid[0]};
        end
    end

    // Next-state and datapath updates for accept, latency count and response.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        alu_ctrl_d   = alu_ctrl_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_data_d   = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (|req_ready_c) begin
                    owner_d      = grant;
                    last_grant_d = grant;
                    cnt_d        = 4'(ALU_LATENCY);
                    alu_ctrl_d   = grant ? bus.req1_ctrl : bus.req0_ctrl;
                    alu_a_d      = grant ? bus.req1_a : bus.req0_a;
                    alu_b_d      = grant ? bus.req1_b : bus.req0_b;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q == 4'd0) begin
                    rsp_data_d = bus.alu_y;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready[owner_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            alu_ctrl_q   <= 4'd0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            alu_ctrl_q   <= alu_ctrl_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = (state_q == S_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.alu_ctrl  = alu_ctrl_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a latency-1 and a latency-3 instance, each fed by a
// pipelined ALU model. Vector table, hand sequences, and a randomized run
// against a transaction-level reference model.
module tb_alu_arbiter;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_err;

    alu_arbiter_if #(.WIDTH(16)) if1 ();
    alu_arbiter_if #(.WIDTH(16)) if3 ();

    alu_arbiter #(.WIDTH(16), .ALU_LATENCY(1)) dut1 (.clk(clk), .resetn(resetn), .bus(if1));
    alu_arbiter #(.WIDTH(16), .ALU_LATENCY(3)) dut3 (.clk(clk), .resetn(resetn), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] alu_f(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
        case (c)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return 16'h0000;
        endcase
    endfunction

    // ALU models: result appears L edges after the operands are presented.
    logic [15:0] p1;
    logic [15:0] p3 [3];
    always @(posedge clk) begin
        p1    <= alu_f(if1.alu_ctrl, if1.alu_a, if1.alu_b);
        p3[0] <= alu_f(if3.alu_ctrl, if3.alu_a, if3.alu_b);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign if1.alu_y = p1;
    assign if3.alu_y = p3[2];

    typedef struct packed {
        logic [1:0]  req_ready;
        logic [1:0]  rsp_valid;
        logic [15:0] rsp_data;
        logic [3:0]  alu_ctrl;
        logic [15:0] alu_a;
        logic [15:0] alu_b;
        logic        busy;
    } obs_t;

    typedef struct {
        bit          s3;
        int          lat;
        int          r;
        logic [3:0]  c;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
    } vec_t;

    function automatic obs_t snap(input bit s3);
        obs_t o;
        if (s3) o = '{if3.req_ready, if3.rsp_valid, if3.rsp_data, if3.alu_ctrl, if3.alu_a, if3.alu_b, if3.busy};
        else    o = '{if1.req_ready, if1.rsp_valid, if1.rsp_data, if1.alu_ctrl, if1.alu_a, if1.alu_b, if1.busy};
        return o;
    endfunction

    function automatic logic [1:0] oh(input int r);
        return (r != 0) ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit s3, input logic [1:0] rv, input logic [1:0] rr,
                         input logic [3:0] c0, input logic [15:0] a0, input logic [15:0] b0,
                         input logic [3:0] c1, input logic [15:0] a1, input logic [15:0] b1);
        if (s3) begin
            if3.req_valid = rv; if3.rsp_ready = rr;
            if3.req0_ctrl = c0; if3.req0_a = a0; if3.req0_b = b0;
            if3.req1_ctrl = c1; if3.req1_a = a1; if3.req1_b = b1;
        end else begin
            if1.req_valid = rv; if1.rsp_ready = rr;
            if1.req0_ctrl = c0; if1.req0_a = a0; if1.req0_b = b0;
            if1.req1_ctrl = c1; if1.req1_a = a1; if1.req1_b = b1;
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        resetn = 1'b0;
        drive(0, 2'b00, 2'b00, 4'd0, 16'd0, 16'd0, 4'd0, 16'd0, 16'd0);
        drive(1, 2'b00, 2'b00, 4'd0, 16'd0, 16'd0, 4'd0, 16'd0, 16'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // One isolated operation with rsp_ready held high; checks the full timeline.
    task automatic run_op(input bit s3, input int lat, input int r, input logic [3:0] c,
                          input logic [15:0] a, input logic [15:0] b, input logic [15:0] y,
                          input string nm);
        obs_t o;
        @(negedge clk);
        if (r != 0) drive(s3, 2'b10, 2'b11, 4'd0, 16'd0, 16'd0, c, a, b);
        else        drive(s3, 2'b01, 2'b11, c, a, b, 4'd0, 16'd0, 16'd0);
        #1 o = snap(s3);
        chk({nm, "_req_ready"}, o.req_ready, oh(r));
        chk({nm, "_busy_idle"}, o.busy, 1'b0);
        @(negedge clk);
        drive(s3, 2'b00, 2'b11, 4'd0, 16'd0, 16'd0, 4'd0, 16'd0, 16'd0);
        o = snap(s3);
        chk({nm, "_busy"}, o.busy, 1'b1);
        chk({nm, "_alu_ops"}, {o.alu_ctrl, o.alu_a, o.alu_b}, {c, a, b});
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            chk({nm, "_early_valid"}, snap(s3).rsp_valid, 2'b00);
        end
        @(negedge clk);
        o = snap(s3);
        chk({nm, "_rsp_valid"}, o.rsp_valid, oh(r));
        chk({nm, "_rsp_data"}, o.rsp_data, y);
        @(negedge clk);
        o = snap(s3);
        chk({nm, "_done_busy"}, o.busy, 1'b0);
        chk({nm, "_done_valid"}, o.rsp_valid, 2'b00);
    endtask

    initial begin
        vec_t        vt[9];
        obs_t        o;
        int          ng;
        int          gcyc[6];
        bit          gsel[6];
        bit          act, lastg, any_acc;
        int          own, ea, w;
        logic [15:0] ed, acc_a;
        logic [3:0]  acc_c;
        logic [1:0]  rv, rr, exp_rv, exp_rdy;
        logic [3:0]  c0, c1;
        logic [15:0] a0, b0, a1, b1;

        n_cmp = 0;
        n_err = 0;
        vt[0] = '{0, 1, 0, OP_ADD, 16'h0003, 16'h0004, 16'h0007};
        vt[1] = '{0, 1, 1, OP_SUB, 16'h0003, 16'h0004, 16'hFFFF};
        vt[2] = '{0, 1, 0, OP_AND, 16'h5A5A, 16'hA5A5, 16'h0000};
        vt[3] = '{0, 1, 1, OP_OR,  16'h5A00, 16'h00A5, 16'h5AA5};
        vt[4] = '{0, 1, 0, OP_XOR, 16'hFFFF, 16'h1234, 16'hEDCB};
        vt[5] = '{0, 1, 1, OP_ADD, 16'hFFFF, 16'h0001, 16'h0000};
        vt[6] = '{0, 1, 0, OP_SUB, 16'h0000, 16'h0001, 16'hFFFF};
        vt[7] = '{1, 3, 0, OP_ADD, 16'h1234, 16'h1111, 16'h2345};
        vt[8] = '{1, 3, 0, OP_AND, 16'h5A5A, 16'hA5A5, 16'h0000};

        resetn = 1'b0;
        drive(0, 2'b00, 2'b00, 4'd0, 16'd0, 16'd0, 4'd0, 16'd0, 16'd0);
        drive(1, 2'b00, 2'b00, 4'd0, 16'd0, 16'd0, 4'd0, 16'd0, 16'd0);
        @(negedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            o = snap(s != 0);
            chk("rst_req_ready", o.req_ready, 2'b00);
            chk("rst_rsp_valid", o.rsp_valid, 2'b00);
            chk("rst_rsp_data", o.rsp_data, 16'h0000);
            chk("rst_alu", {o.alu_ctrl, o.alu_a, o.alu_b}, 36'h0);
            chk("rst_busy", o.busy, 1'b0);
        end
        resetn = 1'b1;

        // Vector table: includes the basic ADD timeline and the latency-3 AND case.
        for (int i = 0; i < 9; i++) begin
            run_op(vt[i].s3, vt[i].lat, vt[i].r, vt[i].c, vt[i].a, vt[i].b, vt[i].y, $sformatf("vec%0d", i));
        end

        // Both requesters held valid: grant order and back-to-back spacing.
        reset_dut();
        ng = 0;
        for (int k = 0; k < 80 && ng < 6; k++) begin
            @(negedge clk);
            o = snap(0);
            if (o.rsp_valid != 2'b00) begin
                if (ng > 0) begin
                    chk("t2_rsp_owner", o.rsp_valid, oh(int'(gsel[ng-1])));
                    chk("t2_rsp_data", o.rsp_data, gsel[ng-1] ? 16'h0FF0 : 16'h0011);
                end else begin
                    chk("t2_rsp_before_grant", o.rsp_valid, 2'b00);
                end
            end
            drive(0, 2'b11, 2'b11, OP_ADD, 16'h0010, 16'h0001, OP_XOR, 16'h00FF, 16'h0F0F);
            #1 o = snap(0);
            if (o.req_ready != 2'b00) begin
                chk("t2_onehot", $countones(o.req_ready), 1);
                gsel[ng] = o.req_ready[1];
                gcyc[ng] = k;
                ng++;
            end
        end
        chk("t2_grant_count", ng, 6);
        for (int i = 0; i < ng; i++) begin
            chk("t2_grant_order", gsel[i], RR ? (i % 2) : 0);
            if (i > 0) chk("t2_spacing", gcyc[i] - gcyc[i-1], 4);
        end
        @(negedge clk);
        drive(0, 2'b00, 2'b11, 4'd0, 16'd0, 16'd0, 4'd0, 16'd0, 16'd0);
        repeat (5) @(negedge clk);

        // req1 alone after reset, response held with rsp_ready low, req0 pending.
        reset_dut();
        @(negedge clk);
        drive(0, 2'b10, 2'b00, OP_ADD, 16'h0100, 16'h0023, OP_SUB, 16'h0003, 16'h0004);
        #1 chk("t3_req1_ready", snap(0).req_ready, 2'b10);
        @(negedge clk);
        drive(0, 2'b01, 2'b00, OP_ADD, 16'h0100, 16'h0023, OP_SUB, 16'h0003, 16'h0004);
        #1 o = snap(0);
        chk("t3_busy", o.busy, 1'b1);
        chk("t3_alu_ops", {o.alu_ctrl, o.alu_a}, {OP_SUB, 16'h0003});
        chk("t3_exec_ready", o.req_ready, 2'b00);
        @(negedge clk);
        chk("t3_early_valid", snap(0).rsp_valid, 2'b00);
        @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            if1.rsp_ready = (j == 2) ? 2'b01 : 2'b00;
            #1 o = snap(0);
            chk("t3_hold_valid", o.rsp_valid, 2'b10);
            chk("t3_hold_data", o.rsp_data, 16'hFFFF);
            chk("t3_hold_ready", o.req_ready, 2'b00);
            @(negedge clk);
        end
        o = snap(0);
        chk("t3_hold_valid_end", o.rsp_valid, 2'b10);
        if1.rsp_ready = 2'b10;
        @(negedge clk);
        #1 o = snap(0);
        chk("t3_idle_busy", o.busy, 1'b0);
        chk("t3_idle_valid", o.rsp_valid, 2'b00);
        chk("t3_req0_ready", o.req_ready, 2'b01);
        if1.rsp_ready = 2'b11;
        @(negedge clk);
        if1.req_valid = 2'b00;
        o = snap(0);
        chk("t3_req0_accept", {o.busy, o.alu_ctrl, o.alu_a}, {1'b1, OP_ADD, 16'h0100});
        @(negedge clk);
        @(negedge clk);
        o = snap(0);
        chk("t3_req0_rsp", {o.rsp_valid, o.rsp_data}, {2'b01, 16'h0123});
        @(negedge clk);

        // Reset asserted for one edge during EXEC.
        @(negedge clk);
        drive(0, 2'b01, 2'b11, OP_ADD, 16'h0001, 16'h0001, 4'd0, 16'd0, 16'd0);
        @(negedge clk);
        if1.req_valid = 2'b00;
        chk("t4_in_exec", snap(0).busy, 1'b1);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        o = snap(0);
        chk("t4_rst_busy", o.busy, 1'b0);
        chk("t4_rst_valid", o.rsp_valid, 2'b00);
        chk("t4_rst_data", o.rsp_data, 16'h0000);
        chk("t4_rst_alu", {o.alu_ctrl, o.alu_a, o.alu_b}, 36'h0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("t4_no_late_valid", snap(0).rsp_valid, 2'b00);
        end
        run_op(0, 1, 0, OP_ADD, 16'h4000, 16'h4000, 16'h8000, "t4_fresh");

        // Randomized traffic against a transaction-level model (latency 1).
        reset_dut();
        act = 1'b0; lastg = 1'b1; any_acc = 1'b0; own = 0; ea = 0; w = 0;
        ed = '0; acc_a = '0; acc_c = '0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            exp_rv = (act && k >= ea + 2) ? oh(own) : 2'b00;
            o = snap(0);
            chk("rnd_rsp_valid", o.rsp_valid, exp_rv);
            chk("rnd_busy", o.busy, act);
            if (exp_rv != 2'b00) chk("rnd_rsp_data", o.rsp_data, ed);
            if (any_acc) chk("rnd_alu_hold", {o.alu_ctrl, o.alu_a}, {acc_c, acc_a});
            rv = 2'($urandom_range(0, 3));
            rr = 2'($urandom_range(0, 3));
            c0 = 4'($urandom_range(0, 4)); a0 = 16'($urandom); b0 = 16'($urandom);
            c1 = 4'($urandom_range(0, 4)); a1 = 16'($urandom); b1 = 16'($urandom);
            drive(0, rv, rr, c0, a0, b0, c1, a1, b1);
            w = (rv == 2'b11) ? (RR ? int'(~lastg) : 0) : int'(rv[1]);
            exp_rdy = (!act && rv != 2'b00) ? oh(w) : 2'b00;
            #1 chk("rnd_req_ready", snap(0).req_ready, exp_rdy);
            if (!act && rv != 2'b00) begin
                act = 1'b1; own = w; lastg = (w != 0); ea = k + 1; any_acc = 1'b1;
                acc_c = (w != 0) ? c1 : c0;
                acc_a = (w != 0) ? a1 : a0;
                ed = (w != 0) ? alu_f(c1, a1, b1) : alu_f(c0, a0, b0);
            end else if (exp_rv != 2'b00 && rr[own]) begin
                act = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 16-bit ALU between two requesters (e.g. execute stage and address-generation unit) using a valid/ready request and response handshake. Runs one operation at a time: grant, drive ALU operands, wait a fixed ALU latency, capture the result, then hold it until the owner accepts it. Sits between the requesters and the `alu` instance. It drives that instance's `ctrl`/`a`/`b` inputs and reads its `y` output.

## Interface
- `WIDTH`, 16, operand/result width.
- `ALU_LATENCY`, 1, edges from operands driven on `alu_*` until `alu_y` is valid; legal 1..15. Values outside this range cause an elaboration `$error`.
- `clk  in  1`  clock; all logic is rising-edge.
- `resetn  in  1`  reset; synchronous, active-low.
- `req_valid  in  2`  request valid, bit i = requester i.
- `req_ready  out  2`  request accepted, bit i = requester i.
- `req0_ctrl`, `req1_ctrl  in  4`  ALU op code (`ALU_OP_*` constants, passed through unmodified).
- `req0_a`, `req0_b`, `req1_a`, `req1_b  in  WIDTH`  operands.
- `rsp_valid  out  2`  result valid for owner bit i.
- `rsp_ready  in  2`  owner i accepts the result.
- `rsp_data  out  WIDTH`  result; shared, qualified by `rsp_valid`.
- `alu_ctrl  out  4`, `alu_a  out  WIDTH`, `alu_b  out  WIDTH`  drive the ALU.
- `alu_y  in  WIDTH`  ALU result.
- `busy  out  1`  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE, grant selection:
  - `req_ready[g]` is asserted combinationally only for the granted requester g, and only if `req_valid[g]` is high.
  - Grant is never given to a non-requesting bit.
- Request handshake (`req_valid[g] & req_ready[g]` at an edge):
  - The ctrl/a/b of requester g are registered onto `alu_ctrl`/`alu_a`/`alu_b`.
  - `owner <= g`, `last_grant <= g`, `cnt <= ALU_LATENCY`, state goes to EXEC.
- EXEC:
  - `cnt` decrements each edge.
  - At the edge where `cnt == 0`, `alu_y` is registered into `rsp_data` and state goes to RESP.
- RESP:
  - `rsp_valid[owner] = 1`.
  - On `rsp_ready[owner]` at an edge, state goes to IDLE.
  - `rsp_ready` on the non-owner bit is ignored.
- `alu_*` outputs hold their last operands until the next accept. They do not return to zero.
- `req_ready` is 0 in EXEC and RESP.
- Dropping `req_valid` before a handshake is legal; the request is simply not accepted.
- Reset values:
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_data` = 0.
  - `alu_ctrl`, `alu_a`, `alu_b` = 0.
  - `busy` = 0, state IDLE, `cnt` = 0.
  - `last_grant` = 1, so requester 0 wins the first contention.
- `resetn` low in any state, including mid-EXEC and RESP, aborts the operation: the in-flight result is discarded and the next edge enters the reset values.

## Timing
- Edge E0: request handshake. After E0, `alu_*` carry the operands and `busy` = 1.
- Edge E0+L+1 (L = `ALU_LATENCY`): `alu_y` is captured. After this edge `rsp_valid[owner]` = 1 and `rsp_data` is stable.
- If `rsp_ready` is already high, the response handshake happens at E0+L+2 and state is IDLE after it.
  - The earliest next accept is E0+L+3.
  - Peak throughput is one operation per L+3 cycles.
- `rsp_valid` and `rsp_data` stay stable while `rsp_ready[owner]` = 0, with no upper limit.

## Configuration
- `ALU_ARB_ROUND_ROBIN_EN` defined: on contention in IDLE, the bit that is not `last_grant` wins. A single requesting bit always wins, whatever `last_grant` holds.
- Undefined: fixed priority, requester 0 always wins contention. `last_grant` is still maintained but unused.

## Test plan
1. L=1, req0 ADD 0x0003+0x0004, `rsp_ready` = 1 -> `req_ready` = 2'b01 at E0; `rsp_valid` = 2'b01 and `rsp_data` = 0x0007 after E2; `busy` = 0 after E3.
2. Both requesters held valid for 6 operations, macro defined -> grant order 0,1,0,1,0,1. Macro undefined -> six grants to 0 and `req_ready[1]` never asserted.
3. req1 SUB 0x0003-0x0004, `rsp_ready` low for 5 cycles -> `rsp_valid` = 2'b10 and `rsp_data` = 0xFFFF held all 5 cycles. A pending req0 sees `req_ready` = 0 throughout and is accepted on the first edge after the response handshake.
4. `resetn` low for one cycle during EXEC -> after that edge all outputs are at reset values, no `rsp_valid` appears later, and a fresh req0 ADD 0x4000+0x4000 completes with 0x8000.
5. `ALU_LATENCY` = 3 with a 3-stage ALU model, AND 0x5A5A&0xA5A5 -> `rsp_valid` rises exactly after E4, `rsp_data` = 0x0000.
6. req1 alone valid with `last_grant` = 1 -> accepted at the first IDLE edge. `rsp_ready[0]` pulsed in RESP is ignored.
